// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: aligns store lanes, checks alignment, runs a
// req/ack bus access with timeout, and extends load results.
module mem_access_unit #(
  parameter int P_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_alu_out_m,
  input  logic [31:0] i_haz_b_m,
  input  logic        i_mem_write_m,
  input  logic [1:0]  i_result_src_m,
  input  logic [2:0]  i_f3_m,
  input  logic        i_store_byte_m,
  input  logic        i_store_half_m,
  output logic        o_stall,
  output logic [31:0] o_load_data_m,
  output logic [3:0]  o_exception_code_m,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);
  localparam int CW = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  localparam logic [3:0] CODE_NONE = 4'b1111;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_addr, r_wdata, r_load;
  logic [3:0]    r_be, r_code;
  logic [1:0]    r_size, r_off;
  logic          r_uns;

  logic        w_load, w_acc;
  logic [1:0]  w_size, w_off;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_load = (i_result_src_m == 2'b01);
  assign w_acc  = i_mem_write_m | w_load;
  assign w_off  = i_alu_out_m[1:0];

  always_comb begin
    w_size = SZ_W;
    if (i_mem_write_m) begin
      if (i_store_byte_m)      w_size = SZ_B;
      else if (i_store_half_m) w_size = SZ_H;
    end else begin
      if (i_f3_m[1:0] == 2'b00)      w_size = SZ_B;
      else if (i_f3_m[1:0] == 2'b01) w_size = SZ_H;
    end
  end

  assign w_mis = ((w_size == SZ_H) && w_off[0]) || ((w_size == SZ_W) && (w_off != 2'b00));

  // Reads always fetch the whole word; lane selection happens on return.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'd0;
    if (i_mem_write_m) begin
      w_wdata = i_haz_b_m;
      case (w_size)
        SZ_B: begin w_be = 4'b0001 << w_off;         w_wdata = {4{i_haz_b_m[7:0]}};  end
        SZ_H: begin w_be = 4'b0011 << {w_off[1], 1'b0}; w_wdata = {2{i_haz_b_m[15:0]}}; end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_off)
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
    w_half = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (r_size)
      SZ_B:    w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
      SZ_H:    w_ext = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_ext = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_size  <= SZ_W;
      r_off   <= 2'd0;
      r_uns   <= 1'b0;
      r_load  <= 32'd0;
      r_code  <= CODE_NONE;
    end else begin
      case (r_state)
        S_IDLE: if (w_acc) begin
          if (w_mis) begin
            r_code  <= i_mem_write_m ? 4'd6 : 4'd4;
            r_state <= S_DONE;
          end else begin
            r_we    <= i_mem_write_m;
            r_addr  <= {i_alu_out_m[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_size  <= w_size;
            r_off   <= w_off;
            r_uns   <= i_f3_m[2];
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (i_mem_ack) begin
            if (!r_we) r_load <= w_ext;
            r_code  <= CODE_NONE;
            r_state <= S_DONE;
          end else if (r_cnt == CW'(P_TIMEOUT - 1)) begin
            r_code  <= r_we ? 4'd7 : 4'd5;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_code  <= CODE_NONE;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_stall            = ((r_state == S_IDLE) & w_acc) | (r_state == S_BUSY);
  assign o_mem_req          = (r_state == S_BUSY);
  assign o_mem_we           = r_we;
  assign o_mem_addr         = r_addr;
  assign o_mem_wdata        = r_wdata;
  assign o_mem_be           = r_be;
  assign o_load_data_m      = r_load;
  assign o_exception_code_m = r_code;
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a transaction-level reference model.
module tb_mem_access_unit;
  localparam int TO = 16;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_alu_out_m, i_haz_b_m, i_mem_rdata;
  logic        i_mem_write_m, i_store_byte_m, i_store_half_m, i_mem_ack;
  logic [1:0]  i_result_src_m;
  logic [2:0]  i_f3_m;
  logic        o_stall, o_mem_req, o_mem_we;
  logic [31:0] o_load_data_m, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_exception_code_m, o_mem_be;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.P_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_alu_out_m(i_alu_out_m), .i_haz_b_m(i_haz_b_m),
    .i_mem_write_m(i_mem_write_m), .i_result_src_m(i_result_src_m), .i_f3_m(i_f3_m),
    .i_store_byte_m(i_store_byte_m), .i_store_half_m(i_store_half_m), .o_stall(o_stall),
    .o_load_data_m(o_load_data_m), .o_exception_code_m(o_exception_code_m),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // kind: 0 none, 1 load, 2 store, 3 load+store flags (store wins)
  task automatic run(input int kind, input logic [31:0] addr, input logic [31:0] data,
                     input logic [2:0] f3, input logic sb, input logic sh,
                     input int delay, input bit never, input logic [31:0] rdata);
    bit st, acc, mis, done;
    int sz, off, cyc, busy, exp_busy;
    logic [31:0] exp_wd, exp_ld, sh_rd;
    logic [3:0] exp_be, exp_code;
    acc = (kind != 0);
    st  = (kind >= 2);
    off = int'(addr[1:0]);
    if (st) sz = sb ? 1 : (sh ? 2 : 4);
    else    sz = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    mis = (off % sz) != 0;
    exp_be = 4'hF;
    exp_wd = data;
    if (st && sz == 1) begin exp_be = 4'(1 << off); exp_wd = {24'd0, data[7:0]} * 32'h0101_0101; end
    if (st && sz == 2) begin exp_be = 4'(3 << off); exp_wd = {16'd0, data[15:0]} * 32'h0001_0001; end
    sh_rd  = rdata >> (8 * off);
    exp_ld = rdata;
    if (sz == 1) exp_ld = (!f3[2] && sh_rd[7])  ? (sh_rd | 32'hFFFF_FF00) : (sh_rd & 32'hFF);
    if (sz == 2) exp_ld = (!f3[2] && sh_rd[15]) ? (sh_rd | 32'hFFFF_0000) : (sh_rd & 32'hFFFF);
    if (mis)        begin exp_code = st ? 4'd6 : 4'd4; exp_busy = 0; end
    else if (never) begin exp_code = st ? 4'd7 : 4'd5; exp_busy = TO; end
    else            begin exp_code = 4'hF; exp_busy = delay + 1; end

    @(posedge i_clk); #1;
    i_alu_out_m    = addr;
    i_haz_b_m      = data;
    i_mem_write_m  = st;
    i_result_src_m = (kind == 1 || kind == 3) ? 2'b01 : 2'(kind == 2 ? 2'b10 : 2'b00);
    i_f3_m         = f3;
    i_store_byte_m = sb;
    i_store_half_m = sh;
    @(negedge i_clk);
    cyc = 1;
    chk("idle_stall", 32'(o_stall), 32'(acc));
    chk("idle_req", 32'(o_mem_req), 0);
    chk("idle_code", 32'(o_exception_code_m), 32'hF);
    if (!acc) return;
    i_mem_ack   = 1'($urandom_range(0, 1));
    i_mem_rdata = $urandom;
    busy = 0;
    done = 0;
    while (!done && cyc < 40) begin
      @(negedge i_clk);
      cyc++;
      if (o_stall) begin
        busy++;
        chk("busy_req", 32'(o_mem_req), 1);
        chk("busy_code", 32'(o_exception_code_m), 32'hF);
        chk("busy_addr", o_mem_addr, {addr[31:2], 2'b00});
        chk("busy_we", 32'(o_mem_we), 32'(st));
        chk("busy_be", 32'(o_mem_be), 32'(exp_be));
        if (st) chk("busy_wdata", o_mem_wdata, exp_wd);
        i_mem_ack   = !never && (busy == delay + 1);
        i_mem_rdata = i_mem_ack ? rdata : $urandom;
      end else begin
        done = 1;
        chk("done_req", 32'(o_mem_req), 0);
        chk("done_code", 32'(o_exception_code_m), 32'(exp_code));
        chk("done_busy_cycles", 32'(busy), 32'(exp_busy));
        chk("done_total_cycles", 32'(cyc), 32'(exp_busy + 2));
        if (!st && !mis && !never) chk("done_load", o_load_data_m, exp_ld);
        i_mem_ack = 1'($urandom_range(0, 1));
      end
    end
    if (!done) chk("done_reached", 0, 1);
  endtask

  initial begin
    i_rst = 1'b1; i_alu_out_m = 0; i_haz_b_m = 0; i_mem_write_m = 0; i_result_src_m = 0;
    i_f3_m = 0; i_store_byte_m = 0; i_store_half_m = 0; i_mem_ack = 0; i_mem_rdata = 0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_req", 32'(o_mem_req), 0);
    chk("rst_code", 32'(o_exception_code_m), 32'hF);
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_load", o_load_data_m, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_be", 32'(o_mem_be), 0);
    i_rst = 1'b0;

    run(1, 32'h1003, 0, 3'b000, 0, 0, 0, 0, 32'h80FF_1234);
    run(2, 32'h2002, 32'h0000_ABCD, 3'b000, 0, 1, 2, 0, 0);
    run(1, 32'h3001, 0, 3'b010, 0, 0, 0, 0, 0);
    run(2, 32'h3002, 32'h1234_5678, 3'b000, 0, 0, 0, 0, 0);
    run(1, 32'h4000, 0, 3'b010, 0, 0, 0, 1, 0);
    run(1, 32'h5002, 0, 3'b101, 0, 0, 0, 0, 32'h9ABC_0000);
    run(2, 32'h5001, 32'h0000_0077, 3'b000, 1, 0, 0, 0, 0);
    run(0, 32'h5001, 0, 3'b000, 0, 0, 0, 0, 0);
    run(2, 32'h6004, 32'hDEAD_BEEF, 3'b000, 0, 0, 0, 1, 0);

    // reset while the bus access is outstanding; a late ack must not revive it
    @(posedge i_clk); #1;
    i_alu_out_m = 32'h7000; i_result_src_m = 2'b01; i_f3_m = 3'b010; i_mem_write_m = 0;
    i_mem_ack = 0;
    repeat (3) @(negedge i_clk);
    chk("pre_rst_req", 32'(o_mem_req), 1);
    i_rst = 1'b1; i_result_src_m = 2'b00;
    @(negedge i_clk);
    chk("midrst_req", 32'(o_mem_req), 0);
    chk("midrst_code", 32'(o_exception_code_m), 32'hF);
    chk("midrst_stall", 32'(o_stall), 0);
    i_rst = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
    @(negedge i_clk);
    chk("late_ack_req", 32'(o_mem_req), 0);
    chk("late_ack_load", o_load_data_m, 0);
    chk("late_ack_code", 32'(o_exception_code_m), 32'hF);
    i_mem_ack = 1'b0;

    for (int n = 0; n < 300; n++) begin
      int k, d;
      bit nv;
      logic [31:0] a;
      k  = $urandom_range(0, 9);
      k  = (k == 0) ? 0 : ((k == 9) ? 3 : ((k < 5) ? 1 : 2));
      a  = $urandom;
      nv = ($urandom_range(0, 19) == 0);
      d  = $urandom_range(0, 4);
      run(k, a, $urandom, 3'($urandom), 1'($urandom), 1'($urandom), d, nv, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store engine that consumes the registered EX/MEM pipeline outputs and executes the data access over a request/acknowledge data-memory bus. It aligns store data and byte enables, checks alignment, sign-/zero-extends load results, holds the pipeline while an access is outstanding, and reports load/store faults with RISC-V exception codes. It sits between the EX/MEM register and the MEM/WB register.

## Interface
- P_TIMEOUT, 16: cycles in BUSY without ack before an access fault is raised (≥2).

- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_alu_out_m  in  32  effective byte address
- i_haz_b_m  in  32  store source data (rs2 after forwarding)
- i_mem_write_m  in  1  store instruction present
- i_result_src_m  in  2  2'b01 = load instruction present
- i_f3_m  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW
- i_store_byte_m  in  1  SB (priority over half)
- i_store_half_m  in  1  SH; neither set = SW
- o_stall  out  1  high = hold IF/ID, ID/EX, EX/MEM (drive clock-enable low)
- o_load_data_m  out  32  extended load result, valid in DONE
- o_exception_code_m  out  4  4=load misaligned, 5=load fault, 6=store misaligned, 7=store fault, 4'b1111=none
- o_mem_req  out  1  bus request
- o_mem_we  out  1  1=write
- o_mem_addr  out  32  word address ({addr[31:2],2'b00})
- o_mem_wdata  out  32  lane-shifted store data
- o_mem_be  out  4  byte enables (all 1111 for reads)
- i_mem_ack  in  1  transfer complete this cycle
- i_mem_rdata  in  32  read word, valid with ack

## Operation
- Access present: A = i_mem_write_m | (i_result_src_m == 2'b01); store wins if both set.
- Size: store from byte/half flags; load from f3[1:0] (00 byte, 01 half, else word).
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0.
- Store lanes: byte → wdata = {4{b[7:0]}}, be = 0001<<addr[1:0]; half → {2{b[15:0]}}, be = 0011<<{addr[1],1'b0}; word → b, be=1111.
- Load extract: select byte/half by addr[1:0]/addr[1] from captured rdata; sign-extend for f3[2]=0, zero-extend for f3[2]=1.
- FSM states IDLE, BUSY, DONE:
  - IDLE: A=0 → stay, o_stall=0. A=1 aligned → latch addr/we/wdata/be/size/f3, go BUSY. A=1 misaligned → latch exception code, go DONE, no bus request.
  - BUSY: o_mem_req=1, bus outputs stable from latches; timeout counter increments. i_mem_ack=1 → capture rdata, clear code to 1111, go DONE. Counter = P_TIMEOUT-1 without ack → code 5/7, go DONE.
  - DONE: o_stall=0, o_load_data_m and o_exception_code_m valid; unconditionally → IDLE.
- o_stall = (IDLE & A) | BUSY.
- Ack outside BUSY ignored.

## Timing
- Reset (any state, including mid-BUSY): next edge → IDLE; o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_mem_be=0, o_load_data_m=0, o_exception_code_m=4'b1111, counter=0, o_stall=0 unless A.
- Minimum aligned access: cycle 0 IDLE with A (stall), cycle 1 BUSY with ack, cycle 2 DONE, pipeline advances at end of cycle 2 → 3 cycles per access; each extra wait cycle adds one.
- Misaligned: cycle 0 IDLE (stall), cycle 1 DONE with code → 2 cycles, o_mem_req never asserted.
- Timeout: fault in DONE at cycle P_TIMEOUT+1 relative to detection.
- o_exception_code_m is 4'b1111 in every state except DONE after a fault; load data held until next DONE.
- Back-to-back accesses: IDLE after DONE evaluates the new EX/MEM contents; no duplicate issue of the completed instruction.

## Test plan
- LB at 0x1003, ack after 1 cycle, rdata 0x80FF_1234 → o_mem_addr 0x1000, be 1111, DONE load 0xFFFF_FF80, code 1111, 3 stall-inclusive cycles.
- SH addr 0x2002, data 0x0000_ABCD, ack after 3 waits → we=1, be 1100, wdata 0xABCD_ABCD, o_stall high 4 cycles then low.
- LW at 0x3001 → no req, DONE code 4; SW at 0x3002 → code 6.
- Load 0x4000, ack never, P_TIMEOUT=16 → req drops after 16 BUSY cycles, DONE code 5.
- LHU at 0x5002, rdata 0x9ABC_0000 → 0x0000_9ABC; then immediate SB 0x5001 data 0x77 → be 0010, wdata 0x7777_7777, exactly one request each.
- Assert i_rst mid-BUSY → next cycle req=0, code 1111, FSM IDLE; late ack ignored.
